f8_3850_status: RTL and testbench

- W (status) register stage directly downstream of the 3850 ALU.
- Commits the ALU flag outputs (c, z, ov, s) into W under a per-instruction update class.
- Supports LR W,J / LR J,W transfers and EI/DI handling of ICB.
- Evaluates BT/BF branch conditions and produces the interrupt-accept qualifier, including the one-instruction deferral the 3850 applies after privileged operations.

---
 rtl/f8_3850_status_if.sv | 44 ++++
 rtl/f8_3850_status.sv | 128 ++++++++++++
 tb/tb_f8_3850_status.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/f8_3850_status_if.sv
// Interface bundling the ALU flag, W transfer, interrupt-control and branch
// signals of the 3850 status stage. The master side is the sequencer/ALU
// that drives the stage; the slave side is the status stage itself.
interface f8_3850_status_if;
  // ALU flag outputs and commit control
  logic       alu_c;
  logic       alu_z;
  logic       alu_ov;
  logic       alu_s;
  logic [1:0] flag_cls;
  logic       flag_we;
  // LR W,J transfer
  logic       w_load;
  logic [4:0] w_in;
  // Interrupt control
  logic       ei;
  logic       di;
  logic       priv;
  logic       instr_done;
  logic       ext_int;
  // Branch evaluation
  logic       br_test;
  logic [3:0] br_mask;
  logic       br_eval;
  // Results
  logic [4:0] w_out;
  logic       br_taken;
  logic       br_valid;
  logic       int_accept;

  modport master (
    output alu_c, alu_z, alu_ov, alu_s, flag_cls, flag_we,
    output w_load, w_in, ei, di, priv, instr_done, ext_int,
    output br_test, br_mask, br_eval,
    input  w_out, br_taken, br_valid, int_accept
  );

  modport slave (
    input  alu_c, alu_z, alu_ov, alu_s, flag_cls, flag_we,
    input  w_load, w_in, ei, di, priv, instr_done, ext_int,
    input  br_test, br_mask, br_eval,
    output w_out, br_taken, br_valid, int_accept
  );
endinterface

// File: rtl/f8_3850_status.sv
// 3850 W (status) register stage: commits ALU flags by update class, handles
// LR W,J loads and EI/DI control of ICB, evaluates BT/BF branch conditions
// against the registered W and produces the registered interrupt-accept
// qualifier including the post-privileged-instruction deferral.
module f8_3850_status #(
  parameter logic [4:0] W_RESET = 5'h00
) (
  input logic             clk,
  input logic             rst,
  f8_3850_status_if.slave bus
);

  // W layout: [0]=S, [1]=C, [2]=Z, [3]=O, [4]=ICB
  logic [4:0] w_r;
  logic       ei_pend_r;
  logic       defer_r;
  logic       br_taken_r;
  logic       br_valid_r;
  logic       int_accept_r;

  logic [3:0] flags_nxt_s;
  logic       icb_nxt_s;
  logic       ei_pend_nxt_s;
  logic [4:0] w_nxt_s;
  logic       ei_pend_fin_s;
  logic       br_hit_s;
  logic       br_taken_nxt_s;
  logic       int_accept_nxt_s;

  // Flag field update selected by the instruction's update class
  always_comb begin
    flags_nxt_s = w_r[3:0];
    if (bus.flag_we) begin
      case (bus.flag_cls)
        2'd0:    flags_nxt_s = w_r[3:0];
        2'd1:    flags_nxt_s = {bus.alu_ov, bus.alu_z, bus.alu_c, bus.alu_s};
        2'd2:    flags_nxt_s = {1'b0, bus.alu_z, 1'b0, bus.alu_s};
        2'd3:    flags_nxt_s = {w_r[3], bus.alu_z, w_r[1], bus.alu_s};
        default: flags_nxt_s = w_r[3:0];
      endcase
    end else begin
      flags_nxt_s = w_r[3:0];
    end
  end

  // ICB and the delayed-EI pending bit; DI dominates a simultaneous EI.
  // EI arms at its own instr_done and sets ICB at the next instr_done.
  always_comb begin
    icb_nxt_s     = w_r[4];
    ei_pend_nxt_s = ei_pend_r;
    if (bus.di) begin
      icb_nxt_s     = 1'b0;
      ei_pend_nxt_s = 1'b0;
    end else if (bus.ei && bus.instr_done) begin
      // An earlier EI still pending completes here, then this EI re-arms.
      if (ei_pend_r) begin
        icb_nxt_s = 1'b1;
      end else begin
        icb_nxt_s = w_r[4];
      end
      ei_pend_nxt_s = 1'b1;
    end else if (ei_pend_r && bus.instr_done) begin
      icb_nxt_s     = 1'b1;
      ei_pend_nxt_s = 1'b0;
    end else begin
      icb_nxt_s     = w_r[4];
      ei_pend_nxt_s = ei_pend_r;
    end
  end

  // LR W,J overrides flag commits and EI/DI, and discards a pending EI
  always_comb begin
    w_nxt_s       = {icb_nxt_s, flags_nxt_s};
    ei_pend_fin_s = ei_pend_nxt_s;
    if (bus.w_load) begin
      w_nxt_s       = bus.w_in;
      ei_pend_fin_s = 1'b0;
    end else begin
      w_nxt_s       = {icb_nxt_s, flags_nxt_s};
      ei_pend_fin_s = ei_pend_nxt_s;
    end
  end

  // Branch test against the current (pre-commit) W and interrupt qualifier
  always_comb begin
    br_hit_s         = |(w_r[3:0] & bus.br_mask);
    br_taken_nxt_s   = br_taken_r;
    int_accept_nxt_s = w_r[4] & bus.ext_int & ~defer_r & ~ei_pend_r;
    if (bus.br_eval) begin
      if (bus.br_test) begin
        br_taken_nxt_s = br_hit_s;
      end else begin
        br_taken_nxt_s = ~br_hit_s;
      end
    end else begin
      br_taken_nxt_s = br_taken_r;
    end
  end

  // State registers with synchronous reset taking precedence over all inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      w_r          <= W_RESET;
      ei_pend_r    <= 1'b0;
      defer_r      <= 1'b0;
      br_taken_r   <= 1'b0;
      br_valid_r   <= 1'b0;
      int_accept_r <= 1'b0;
    end else begin
      w_r          <= w_nxt_s;
      ei_pend_r    <= ei_pend_fin_s;
      if (bus.instr_done) begin
        defer_r <= bus.priv;
      end else begin
        defer_r <= defer_r;
      end
      br_taken_r   <= br_taken_nxt_s;
      br_valid_r   <= bus.br_eval;
      int_accept_r <= int_accept_nxt_s;
    end
  end

  assign bus.w_out      = w_r;
  assign bus.br_taken   = br_taken_r;
  assign bus.br_valid   = br_valid_r;
  assign bus.int_accept = int_accept_r;

endmodule

// File: tb/tb_f8_3850_status.sv
// Directed self-checking bench for the 3850 W status stage.
module tb_f8_3850_status;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  f8_3850_status_if bus ();

  f8_3850_status #(.W_RESET(5'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_c = 1'b0; bus.alu_z = 1'b0; bus.alu_ov = 1'b0; bus.alu_s = 1'b0;
    bus.flag_cls = 2'd0; bus.flag_we = 1'b0;
    bus.w_load = 1'b0; bus.w_in = 5'h00;
    bus.ei = 1'b0; bus.di = 1'b0; bus.priv = 1'b0; bus.instr_done = 1'b0;
    bus.br_test = 1'b0; bus.br_mask = 4'h0; bus.br_eval = 1'b0;
  endtask

  task automatic flags(input logic [1:0] cls, input logic c, input logic z,
                       input logic ov, input logic s);
    bus.flag_we = 1'b1; bus.flag_cls = cls;
    bus.alu_c = c; bus.alu_z = z; bus.alu_ov = ov; bus.alu_s = s;
  endtask

  task automatic branch(input logic bt, input logic [3:0] mask);
    bus.br_eval = 1'b1; bus.br_test = bt; bus.br_mask = mask;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle();
    bus.ext_int = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check_eq("reset_w", {3'd0, bus.w_out}, 8'h00);
    check_eq("reset_taken", {7'd0, bus.br_taken}, 8'h00);
    check_eq("reset_valid", {7'd0, bus.br_valid}, 8'h00);
    check_eq("reset_int", {7'd0, bus.int_accept}, 8'h00);

    // Arithmetic class: O=1, C=1
    flags(2'd1, 1'b1, 1'b0, 1'b1, 1'b0); tick(); idle();
    check_eq("cls1", {3'd0, bus.w_out}, 8'h0A);
    // Logic class clears C,O
    flags(2'd2, 1'b1, 1'b1, 1'b1, 1'b1); tick(); idle();
    check_eq("cls2", {3'd0, bus.w_out}, 8'h05);
    // w_load beats flag_we
    bus.w_load = 1'b1; bus.w_in = 5'h1F; flags(2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); idle();
    check_eq("load_prio", {3'd0, bus.w_out}, 8'h1F);
    // sz_only holds C,O and ICB
    flags(2'd3, 1'b0, 1'b0, 1'b0, 1'b0); tick(); idle();
    check_eq("cls3", {3'd0, bus.w_out}, 8'h1A);
    // class 0 leaves W alone
    flags(2'd0, 1'b1, 1'b1, 1'b1, 1'b1); tick(); idle();
    check_eq("cls0", {3'd0, bus.w_out}, 8'h1A);

    // EI takes effect one instruction late
    bus.w_load = 1'b1; bus.w_in = 5'h00; tick(); idle();
    bus.ext_int = 1'b1;
    bus.ei = 1'b1; bus.instr_done = 1'b1; tick(); idle();
    check_eq("ei_icb_first", {7'd0, bus.w_out[4]}, 8'h00);
    tick();
    check_eq("ei_icb_mid", {7'd0, bus.w_out[4]}, 8'h00);
    check_eq("ei_int_mid", {7'd0, bus.int_accept}, 8'h00);
    bus.instr_done = 1'b1; tick(); idle();
    check_eq("ei_icb_second", {7'd0, bus.w_out[4]}, 8'h01);
    check_eq("ei_int_same", {7'd0, bus.int_accept}, 8'h00);
    tick();
    check_eq("ei_int_after", {7'd0, bus.int_accept}, 8'h01);

    // Privileged instruction defers interrupt acceptance
    bus.priv = 1'b1; bus.instr_done = 1'b1; tick(); idle();
    tick();
    check_eq("defer_int0", {7'd0, bus.int_accept}, 8'h00);
    tick();
    check_eq("defer_int0b", {7'd0, bus.int_accept}, 8'h00);
    bus.instr_done = 1'b1; tick(); idle();
    check_eq("defer_int_edge", {7'd0, bus.int_accept}, 8'h00);
    tick();
    check_eq("defer_int1", {7'd0, bus.int_accept}, 8'h01);
    bus.ext_int = 1'b0;

    // Branch conditions with Z set
    bus.w_load = 1'b1; bus.w_in = 5'b00100; tick(); idle();
    branch(1'b1, 4'b0100); tick(); idle();
    check_eq("bt_z_taken", {7'd0, bus.br_taken}, 8'h01);
    check_eq("bt_z_valid", {7'd0, bus.br_valid}, 8'h01);
    tick();
    check_eq("bt_valid_drop", {7'd0, bus.br_valid}, 8'h00);
    check_eq("bt_taken_hold", {7'd0, bus.br_taken}, 8'h01);
    branch(1'b0, 4'b0100); tick(); idle();
    check_eq("bf_z_taken", {7'd0, bus.br_taken}, 8'h00);
    check_eq("bf_z_valid", {7'd0, bus.br_valid}, 8'h01);
    tick();
    check_eq("bf_valid_drop", {7'd0, bus.br_valid}, 8'h00);
    branch(1'b0, 4'b0000); tick(); idle();
    check_eq("bf_uncond", {7'd0, bus.br_taken}, 8'h01);
    branch(1'b1, 4'b0000); tick(); idle();
    check_eq("bt_never", {7'd0, bus.br_taken}, 8'h00);
    // Back-to-back evaluations
    branch(1'b1, 4'b0001); tick();
    check_eq("b2b_1_taken", {7'd0, bus.br_taken}, 8'h00);
    check_eq("b2b_1_valid", {7'd0, bus.br_valid}, 8'h01);
    branch(1'b1, 4'b0100); tick(); idle();
    check_eq("b2b_2_taken", {7'd0, bus.br_taken}, 8'h01);
    check_eq("b2b_2_valid", {7'd0, bus.br_valid}, 8'h01);
    // No bypass: branch sees W before the same-cycle commit
    flags(2'd1, 1'b0, 1'b0, 1'b0, 1'b0); branch(1'b1, 4'b0100); tick(); idle();
    check_eq("nobypass_taken", {7'd0, bus.br_taken}, 8'h01);
    check_eq("nobypass_w", {3'd0, bus.w_out}, 8'h00);

    // EI and DI together: DI wins, nothing pending
    bus.w_load = 1'b1; bus.w_in = 5'h10; tick(); idle();
    bus.ei = 1'b1; bus.di = 1'b1; bus.instr_done = 1'b1; tick(); idle();
    check_eq("eidi_icb", {7'd0, bus.w_out[4]}, 8'h00);
    bus.instr_done = 1'b1; tick(); idle();
    check_eq("eidi_nopend", {7'd0, bus.w_out[4]}, 8'h00);

    // Reset with EI pending and defer set
    bus.ext_int = 1'b1;
    bus.w_load = 1'b1; bus.w_in = 5'h11; tick(); idle();
    bus.ei = 1'b1; bus.priv = 1'b1; bus.instr_done = 1'b1; branch(1'b1, 4'hF);
    tick(); idle();
    check_eq("pre_rst_valid", {7'd0, bus.br_valid}, 8'h01);
    check_eq("pre_rst_int", {7'd0, bus.int_accept}, 8'h01);
    rst = 1'b1; bus.w_load = 1'b1; bus.w_in = 5'h1F; branch(1'b1, 4'hF);
    tick(); idle(); rst = 1'b0;
    check_eq("rst_w", {3'd0, bus.w_out}, 8'h00);
    check_eq("rst_taken", {7'd0, bus.br_taken}, 8'h00);
    check_eq("rst_valid", {7'd0, bus.br_valid}, 8'h00);
    check_eq("rst_int", {7'd0, bus.int_accept}, 8'h00);
    bus.instr_done = 1'b1; tick(); idle();
    check_eq("rst_pend_gone", {3'd0, bus.w_out}, 8'h00);
    bus.w_load = 1'b1; bus.w_in = 5'h10; tick(); idle();
    tick();
    check_eq("rst_defer_gone", {7'd0, bus.int_accept}, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
